// File: rtl/usb_rx_pkg.sv
// Shared state encoding and line-protocol constants for the USB receive sequencer.
package usb_rx_pkg;

  localparam logic [2:0] SYNC_MIN_ZEROS = 3'd6;
  localparam logic [2:0] EOP_SE0_BITS   = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_PACKET = 3'd2,
    ST_EOP    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } rx_state_e;

endpackage

// File: rtl/usb_rx_run_counter.sv
// Saturating 3-bit run-length counter; clear together with increment loads 1.
module usb_rx_run_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [2:0] cnt_o
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? 3'd1 : '0;
    end else if (inc_i && (cnt_q != 3'd7)) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/usb_rx_sequencer.sv
// Packet framing ahead of the bit unstuffer: SYNC detection, data forwarding,
// EOP validation and packet-length overrun abort.
module usb_rx_sequencer
  import usb_rx_pkg::*;
#(
  parameter logic [9:0] MAX_PKT_BITS = 10'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bstr_in,
  input  logic       bit_valid,
  input  logic       se0_in,
  output logic       bstr_out,
  output logic       bstr_out_avail,
  output logic       pkt_done,
  output logic       pkt_start,
  output logic       rx_err,
  output logic       busy,
  output logic [9:0] bit_cnt
);

  rx_state_e  state_q, state_d;
  logic [9:0] bit_cnt_q, bit_cnt_d;
  logic       start_q, start_d;
  logic [2:0] zero_run, se0_run;
  logic       zr_clr, zr_inc, se_clr, se_inc;
  logic       data_bit, se0_bit, overrun;

  assign data_bit = bit_valid && !se0_in;
  assign se0_bit  = bit_valid && se0_in;
  assign overrun  = data_bit && (bit_cnt_q == MAX_PKT_BITS);

  usb_rx_run_counter u_zero_run (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (zr_clr),
    .inc_i (zr_inc),
    .cnt_o (zero_run)
  );

  usb_rx_run_counter u_se0_run (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (se_clr),
    .inc_i (se_inc),
    .cnt_o (se0_run)
  );

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    start_d        = start_q;
    zr_clr         = 1'b0;
    zr_inc         = 1'b0;
    se_clr         = 1'b0;
    se_inc         = 1'b0;
    bstr_out_avail = 1'b0;
    pkt_start      = 1'b0;
    pkt_done       = 1'b0;
    rx_err         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (data_bit && !bstr_in) begin
          state_d = ST_SYNC;
          zr_clr  = 1'b1;
          zr_inc  = 1'b1;
        end
      end
      ST_SYNC: begin
        if (se0_bit) begin
          state_d = ST_IDLE;
          zr_clr  = 1'b1;
        end else if (data_bit) begin
          if (!bstr_in) begin
            zr_inc = 1'b1;
          end else begin
            zr_clr = 1'b1;
            if (zero_run >= SYNC_MIN_ZEROS) begin
              state_d   = ST_PACKET;
              bit_cnt_d = '0;
              start_d   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_PACKET: begin
        // pkt_start waits for the first valid cycle so gapped streams still see it once.
        if (bit_valid) begin
          pkt_start = start_q;
          start_d   = 1'b0;
        end
        if (se0_bit) begin
          state_d        = ST_EOP;
          bstr_out_avail = 1'b1;
          se_clr         = 1'b1;
          se_inc         = 1'b1;
        end else if (overrun) begin
          state_d = ST_ERR;
        end else if (data_bit) begin
          bstr_out_avail = 1'b1;
          bit_cnt_d      = bit_cnt_q + 10'd1;
        end
      end
      ST_EOP: begin
        if (bit_valid) begin
          bstr_out_avail = 1'b1;
          if (se0_in) begin
            if (se0_run == EOP_SE0_BITS) state_d = ST_ERR;
            else                         se_inc  = 1'b1;
          end else if (bstr_in && (se0_run == EOP_SE0_BITS)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DONE: begin
        pkt_done = 1'b1;
        se_clr   = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_ERR: begin
        rx_err  = 1'b1;
        se_clr  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      start_q   <= start_d;
    end
  end

  assign bstr_out = bstr_in;
  assign busy     = (state_q != ST_IDLE);
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Directed bench for usb_rx_sequencer: a default instance and a 20-bit-limit instance share stimulus.
module tb_usb_rx_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bstr_in, bit_valid, se0_in;
  logic       out_a, avail_a, done_a, start_a, err_a, busy_a;
  logic [9:0] cnt_a;
  logic       out_b, avail_b, done_b, start_b, err_b, busy_b;
  logic [9:0] cnt_b;

  always #5 clk = ~clk;

  usb_rx_sequencer dut_a (
    .clk(clk), .rst(rst), .bstr_in(bstr_in), .bit_valid(bit_valid), .se0_in(se0_in),
    .bstr_out(out_a), .bstr_out_avail(avail_a), .pkt_done(done_a), .pkt_start(start_a),
    .rx_err(err_a), .busy(busy_a), .bit_cnt(cnt_a)
  );

  usb_rx_sequencer #(.MAX_PKT_BITS(10'd20)) dut_b (
    .clk(clk), .rst(rst), .bstr_in(bstr_in), .bit_valid(bit_valid), .se0_in(se0_in),
    .bstr_out(out_b), .bstr_out_avail(avail_b), .pkt_done(done_b), .pkt_start(start_b),
    .rx_err(err_b), .busy(busy_b), .bit_cnt(cnt_b)
  );

  int tot_start = 0, tot_avail = 0, tot_done = 0, tot_err = 0;
  int b_avail = 0, b_err = 0, b_done = 0;

  always @(negedge clk) begin
    if (!rst) begin
      tot_start += int'(start_a);
      tot_avail += int'(avail_a);
      tot_done  += int'(done_a);
      tot_err   += int'(err_a);
      b_avail   += int'(avail_b);
      b_err     += int'(err_b);
      b_done    += int'(done_b);
    end
  end

  int n_checks = 0, n_errors = 0;
  int s_start, s_avail, s_done, s_err, sb_avail, sb_err, sb_done;
  bit gap_mode = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_start = tot_start; s_avail = tot_avail; s_done = tot_done; s_err = tot_err;
    sb_avail = b_avail; sb_err = b_err; sb_done = b_done;
  endtask

  task automatic drive(input logic v, input logic b, input logic s);
    @(posedge clk); #1;
    bit_valid = v; bstr_in = b; se0_in = s;
  endtask

  // Gap cycles carry misleading bstr/se0 values to prove they are ignored.
  task automatic sbit(input logic b, input logic s);
    drive(1'b1, b, s);
    if (gap_mode) drive(1'b0, ~b, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic sync(input int zeros);
    for (int i = 0; i < zeros; i++) sbit(1'b0, 1'b0);
    sbit(1'b1, 1'b0);
  endtask

  task automatic data(input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) sbit(pat[i], 1'b0);
  endtask

  task automatic eop_good();
    sbit(1'b0, 1'b1); sbit(1'b0, 1'b1); sbit(1'b1, 1'b0);
  endtask

  task automatic good_packet_checks(input string pfx);
    check({pfx, "_start"}, tot_start - s_start, 1);
    check({pfx, "_avail"}, tot_avail - s_avail, 19);
    check({pfx, "_done"},  tot_done - s_done, 1);
    check({pfx, "_err"},   tot_err - s_err, 0);
    check({pfx, "_cnt"},   int'(cnt_a), 16);
    check({pfx, "_busy"},  int'(busy_a), 0);
  endtask

  initial begin
    rst = 1'b1; bit_valid = 1'b0; bstr_in = 1'b0; se0_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy_a), 0);
    check("rst_avail", int'(avail_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_start", int'(start_a), 0);
    check("rst_err", int'(err_a), 0);
    check("rst_cnt", int'(cnt_a), 0);
    bstr_in = 1'b0; #1 check("passthru0", int'(out_a), 0);
    bstr_in = 1'b1; #1 check("passthru1", int'(out_a), 1);
    rst = 1'b0;
    idle(2);

    // Good packet, 16 data bits
    snap(); sync(7); data(32'hA5C3, 16); eop_good(); idle(3);
    good_packet_checks("good");

    // Short sync run
    snap(); sync(4); data(32'b01001101, 8); idle(3);
    check("short_start", tot_start - s_start, 0);
    check("short_avail", tot_avail - s_avail, 0);
    check("short_busy", int'(busy_a), 0);

    // Single SE0 then J
    snap(); sync(7); data(32'h5A, 8); sbit(1'b0, 1'b1); sbit(1'b1, 1'b0); idle(3);
    check("badeop_err", tot_err - s_err, 1);
    check("badeop_done", tot_done - s_done, 0);
    check("badeop_avail", tot_avail - s_avail, 10);
    check("badeop_cnt", int'(cnt_a), 8);
    check("badeop_busy", int'(busy_a), 0);

    // 25 data bits: default instance completes, 20-bit instance overruns
    snap(); sync(7); data(32'h1FFFFFF, 25); eop_good(); idle(3);
    check("ovr_b_avail", b_avail - sb_avail, 20);
    check("ovr_b_err", b_err - sb_err, 1);
    check("ovr_b_done", b_done - sb_done, 0);
    check("ovr_b_cnt", int'(cnt_b), 20);
    check("ovr_b_busy", int'(busy_b), 0);
    check("ovr_a_done", tot_done - s_done, 1);
    check("ovr_a_avail", tot_avail - s_avail, 28);
    check("ovr_a_cnt", int'(cnt_a), 25);

    // Reset mid-packet
    snap(); sync(7); data(32'h2B5, 10);
    @(posedge clk); #1;
    check("mid_cnt", int'(cnt_a), 10);
    check("mid_busy", int'(busy_a), 1);
    rst = 1'b1; #1;
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_avail", int'(avail_a), 0);
    check("midrst_start", int'(start_a), 0);
    check("midrst_done", int'(done_a), 0);
    check("midrst_err", int'(err_a), 0);
    check("midrst_cnt", int'(cnt_a), 0);
    #1 rst = 1'b0;
    idle(2);
    check("midrst_nopulse", (tot_err - s_err) + (tot_done - s_done), 0);
    snap(); sync(7); data(32'hA5C3, 16); eop_good(); idle(3);
    good_packet_checks("postrst");

    // Same good packet with invalid cycle after every bit
    gap_mode = 1'b1;
    snap(); sync(7); data(32'hA5C3, 16); eop_good(); idle(3);
    good_packet_checks("gap");
    gap_mode = 1'b0;

    // Exactly six sync zeros is enough
    snap(); sync(6); data(32'b101, 3); eop_good(); idle(3);
    check("six_start", tot_start - s_start, 1);
    check("six_done", tot_done - s_done, 1);
    check("six_cnt", int'(cnt_a), 3);

    // Five zeros is not
    snap(); sync(5); idle(3);
    check("five_start", tot_start - s_start, 0);

    // Three SE0 bits abort
    snap(); sync(7); data(32'b1101, 4);
    sbit(1'b0, 1'b1); sbit(1'b0, 1'b1); sbit(1'b0, 1'b1); idle(3);
    check("se0x3_err", tot_err - s_err, 1);
    check("se0x3_done", tot_done - s_done, 0);
    check("se0x3_avail", tot_avail - s_avail, 7);
    check("se0x3_busy", int'(busy_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
